// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: grants one AXI-Stream input per packet,
// holds the grant through TLAST and muxes the granted stream onto the output.
module axis_packet_arbiter #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned USER_WIDTH         = 1,
  parameter int unsigned INPUT_NUMBER       = 5,
  parameter int unsigned INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [INPUT_NUMBER-1:0]                i_tvalid,
  output logic [INPUT_NUMBER-1:0]                o_tready,
  input  logic [INPUT_NUMBER-1:0][DATA_WIDTH-1:0] i_tdata,
  input  logic [INPUT_NUMBER-1:0][USER_WIDTH-1:0] i_tuser,
  input  logic [INPUT_NUMBER-1:0]                i_tlast,
  output logic                                   o_tvalid,
  input  logic                                   i_tready,
  output logic [DATA_WIDTH-1:0]                  o_tdata,
  output logic [USER_WIDTH-1:0]                  o_tuser,
  output logic                                   o_tlast,
  output logic [INPUT_NUMBER_WIDTH-1:0]          o_current_grant,
  output logic                                   o_grant_valid
);

  localparam int unsigned W = INPUT_NUMBER_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_rr_ptr;
  logic [W-1:0]   r_grant;

  logic           w_any;
  logic [W-1:0]   w_sel;
  logic [W-1:0]   w_idx;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_next_ptr;
  logic           w_last_hs;

  // Round-robin search: first requester at or after r_rr_ptr, modulo INPUT_NUMBER
  always_comb begin
    w_any = 1'b0;
    w_sel = r_rr_ptr;
    w_idx = '0;
    w_sum = '0;
    for (int unsigned k = 0; k < INPUT_NUMBER; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (W+1)'(k);
      if (w_sum >= (W+1)'(INPUT_NUMBER)) begin
        w_sum = w_sum - (W+1)'(INPUT_NUMBER);
      end
      w_idx = w_sum[W-1:0];
      if (!w_any && i_tvalid[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // Packet end detection and next search start (wraps after the last input)
  always_comb begin
    w_last_hs  = (r_state == BUSY) && i_tvalid[r_grant] && i_tready && i_tlast[r_grant];
    w_next_ptr = (r_grant == W'(INPUT_NUMBER - 1)) ? '0 : r_grant + 1'b1;
  end

  // Arbitration FSM: grant in IDLE, release on the TLAST handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_last_hs) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Combinational pass-through of the granted stream; everything zero in IDLE
  always_comb begin
    o_tvalid = 1'b0;
    o_tdata  = '0;
    o_tuser  = '0;
    o_tlast  = 1'b0;
    o_tready = '0;
    if (r_state == BUSY) begin
      o_tvalid          = i_tvalid[r_grant];
      o_tdata           = i_tdata[r_grant];
      o_tuser           = i_tuser[r_grant];
      o_tlast           = i_tlast[r_grant];
      o_tready[r_grant] = i_tready;
    end
  end

  assign o_current_grant = r_grant;
  assign o_grant_valid   = (r_state == BUSY);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed self-checking bench for axis_packet_arbiter (5 inputs, 32-bit data).
module tb_axis_packet_arbiter;

  logic             clk;
  logic             rst_n;
  logic [4:0]       tvalid;
  logic [4:0]       tready_o;
  logic [4:0][31:0] tdata;
  logic [4:0][0:0]  tuser;
  logic [4:0]       tlast;
  logic             out_tvalid;
  logic             out_tready;
  logic [31:0]      out_tdata;
  logic [0:0]       out_tuser;
  logic             out_tlast;
  logic [2:0]       grant;
  logic             grant_valid;

  int checks = 0;
  int errors = 0;

  axis_packet_arbiter #(
    .DATA_WIDTH(32),
    .USER_WIDTH(1),
    .INPUT_NUMBER(5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_tvalid        (tvalid),
    .o_tready        (tready_o),
    .i_tdata         (tdata),
    .i_tuser         (tuser),
    .i_tlast         (tlast),
    .o_tvalid        (out_tvalid),
    .i_tready        (out_tready),
    .o_tdata         (out_tdata),
    .o_tuser         (out_tuser),
    .o_tlast         (out_tlast),
    .o_current_grant (grant),
    .o_grant_valid   (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    tvalid     = '0;
    tlast      = '0;
    tdata      = '0;
    tuser      = '0;
    out_tready = 1'b1;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Round-robin order expected for inputs 0,1,3 starting from rr_ptr=0
  int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    // ---------------- Reset with all inputs valid ----------------
    rst_n      = 1'b0;
    out_tready = 1'b1;
    tuser      = '0;
    tlast      = 5'b11111;
    for (int i = 0; i < 5; i++) tdata[i] = 32'(i) + 32'h100;
    tvalid = 5'b11111;
    step();
    step();
    chk("rst_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("rst_tready", {27'd0, tready_o}, 32'd0);
    chk("rst_grant", {29'd0, grant}, 32'd0);
    chk("rst_gv", {31'd0, grant_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_idle_gv", {31'd0, grant_valid}, 32'd0);
    step();
    chk("rel_grant", {29'd0, grant}, 32'd0);
    chk("rel_gv", {31'd0, grant_valid}, 32'd1);
    chk("rel_tdata", out_tdata, 32'h100);
    chk("rel_tready", {27'd0, tready_o}, 32'h01);

    // ---------------- Single requester: input 2, 4 beats ----------------
    reset_dut();
    tvalid[2] = 1'b1;
    tdata[2]  = 32'hA0;
    tuser[2]  = 1'b1;
    #1;
    chk("sr_idle_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("sr_idle_tready", {27'd0, tready_o}, 32'd0);
    step();
    chk("sr_grant", {29'd0, grant}, 32'd2);
    chk("sr_tready", {27'd0, tready_o}, 32'h04);
    chk("sr_tuser", {31'd0, out_tuser}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      tdata[2] = 32'hA0 + 32'(b);
      tlast[2] = (b == 3);
      #1;
      chk("sr_tdata", out_tdata, 32'hA0 + 32'(b));
      chk("sr_tlast", {31'd0, out_tlast}, (b == 3) ? 32'd1 : 32'd0);
      chk("sr_gv", {31'd0, grant_valid}, 32'd1);
      step();
    end
    tvalid[2] = 1'b0;
    tlast[2]  = 1'b0;
    tuser[2]  = 1'b0;
    #1;
    chk("sr_end_gv", {31'd0, grant_valid}, 32'd0);
    chk("sr_end_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("sr_end_grant_hold", {29'd0, grant}, 32'd2);

    // ---------------- Round robin: inputs 0,1,3 with 2-beat packets ----------------
    reset_dut();
    tdata[0] = 32'h00;
    tdata[1] = 32'h10;
    tdata[3] = 32'h30;
    tvalid   = 5'b01011;
    for (int p = 0; p < 6; p++) begin
      step();
      chk("rr_grant", {29'd0, grant}, 32'(rr_seq[p]));
      chk("rr_tready", {27'd0, tready_o}, 32'd1 << rr_seq[p]);
      for (int b = 0; b < 2; b++) begin
        tdata[rr_seq[p]] = 32'(rr_seq[p]) * 32'h10 + 32'(b);
        tlast[rr_seq[p]] = (b == 1);
        #1;
        chk("rr_tdata", out_tdata, 32'(rr_seq[p]) * 32'h10 + 32'(b));
        step();
      end
      tdata[rr_seq[p]] = 32'(rr_seq[p]) * 32'h10;
      tlast[rr_seq[p]] = 1'b0;
      #1;
      chk("rr_gap_gv", {31'd0, grant_valid}, 32'd0);
    end

    // ---------------- Wrap: rr_ptr=4, inputs 4 and 1 ----------------
    tvalid   = 5'b10010;
    tlast    = 5'b10010;
    tdata[4] = 32'h44;
    tdata[1] = 32'h11;
    tdata[2] = 32'h22;
    step();
    chk("wr_grant4", {29'd0, grant}, 32'd4);
    chk("wr_tdata4", out_tdata, 32'h44);
    step();
    tvalid = 5'b00110;
    tlast  = 5'b00110;
    #1;
    chk("wr_gap_gv", {31'd0, grant_valid}, 32'd0);
    step();
    chk("wr_grant1", {29'd0, grant}, 32'd1);
    chk("wr_tdata1", out_tdata, 32'h11);
    step();
    tvalid = 5'b00100;
    step();
    chk("wr_grant2", {29'd0, grant}, 32'd2);
    step();
    tvalid = '0;
    tlast  = '0;
    #1;
    chk("wr_end_gv", {31'd0, grant_valid}, 32'd0);

    // ---------------- Backpressure: input 3, 3 beats, input 4 competing ----------------
    tvalid   = 5'b11000;
    tdata[3] = 32'h30;
    tdata[4] = 32'h40;
    step();
    chk("bp_grant", {29'd0, grant}, 32'd3);
    chk("bp_tdata0", out_tdata, 32'h30);
    step();
    tdata[3]   = 32'h31;
    out_tready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_stall_tdata", out_tdata, 32'h31);
      chk("bp_stall_tready", {27'd0, tready_o}, 32'd0);
      chk("bp_stall_grant", {29'd0, grant}, 32'd3);
      chk("bp_stall_gv", {31'd0, grant_valid}, 32'd1);
      step();
    end
    out_tready = 1'b1;
    #1;
    chk("bp_resume_tdata", out_tdata, 32'h31);
    chk("bp_resume_tready", {27'd0, tready_o}, 32'h08);
    step();
    tdata[3] = 32'h32;
    tlast[3] = 1'b1;
    #1;
    chk("bp_last_tdata", out_tdata, 32'h32);
    step();
    tvalid[3] = 1'b0;
    tlast[3]  = 1'b0;
    #1;
    chk("bp_end_gv", {31'd0, grant_valid}, 32'd0);
    chk("bp_end_grant", {29'd0, grant}, 32'd3);

    // ---------------- Mid-packet reset: input 4, 4 beats ----------------
    step();
    chk("mr_grant", {29'd0, grant}, 32'd4);
    chk("mr_tdata0", out_tdata, 32'h40);
    step();
    tdata[4] = 32'h41;
    step();
    tdata[4]  = 32'h42;
    tvalid[1] = 1'b1;
    tdata[1]  = 32'h1F;
    #1;
    chk("mr_pre_tdata", out_tdata, 32'h42);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("mr_rst_tready", {27'd0, tready_o}, 32'd0);
    chk("mr_rst_grant", {29'd0, grant}, 32'd0);
    chk("mr_rst_gv", {31'd0, grant_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_restart_grant", {29'd0, grant}, 32'd1);
    chk("mr_restart_tdata", out_tdata, 32'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
